// File: rtl/parity_frame_scheduler.sv
// -----------------------------------------------------------------------------
// parity_frame_scheduler
//
// Lets NUM_REQ word producers share one serial parity path. A round-robin
// arbiter selects one requester at a time. The selected word is shifted out
// LSB-first on ser_*, one bit per cycle, and its parity is accumulated as the
// bits leave. When the frame is complete, the parity is returned together with
// the requester id and the original word, and held until the consumer accepts
// it.
//
// Handshakes:
//   req_valid/req_ready : a word is accepted in the cycle where req_ready[i]
//                         is high. req_ready is a combinational one-hot grant
//                         and can only be high while the block is idle.
//   res_valid/res_ready : the result is held stable while res_valid=1 and
//                         res_ready=0. It is consumed in the cycle where both
//                         are high.
//   ser_*               : there is no back-pressure. The downstream path must
//                         take one bit per cycle while ser_valid=1.
//
// Ports:
//   clk, reset          clock (rising edge), synchronous active-high reset
//   req_valid[NUM_REQ]  per-requester word valid
//   req_data            word i is at [i*DATA_W +: DATA_W]
//   req_ready[NUM_REQ]  one-hot grant pulse
//   odd_mode            1 = odd parity, 0 = even; sampled at grant
//   ser_valid/bit/first/last  serial frame, LSB first
//   res_valid/ready     result handshake
//   res_parity/id/data  parity, granted index, serialized word
//   busy                high whenever the FSM is not idle
// -----------------------------------------------------------------------------
module parity_frame_scheduler #(
   parameter int NUM_REQ = 4,
   parameter int DATA_W  = 8,
   parameter int ID_W    = $clog2(NUM_REQ)
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ*DATA_W-1:0] req_data,
   output logic [NUM_REQ-1:0]        req_ready,
   input  logic                      odd_mode,
   output logic                      ser_valid,
   output logic                      ser_bit,
   output logic                      ser_first,
   output logic                      ser_last,
   output logic                      res_valid,
   input  logic                      res_ready,
   output logic                      res_parity,
   output logic [ID_W-1:0]           res_id,
   output logic [DATA_W-1:0]         res_data,
   output logic                      busy
);

   localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t              state;
   logic [ID_W-1:0]     ptr;      // index of the most recent grant
   logic [ID_W-1:0]     id_l;
   logic [DATA_W-1:0]   shreg;
   logic [DATA_W-1:0]   data_l;
   logic [CNT_W-1:0]    cnt;
   logic                acc;
   logic                odd_l;

   logic                grant_any;
   logic [ID_W-1:0]     grant_idx;
   logic [ID_W-1:0]     cand_idx;
   int                  cand;

   // Round-robin search: try ptr+1, ptr+2, ... with wrap, so the previous
   // winner is considered last.
   always_comb begin
      grant_any = 1'b0;
      grant_idx = '0;
      cand      = 0;
      cand_idx  = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         cand     = (int'(ptr) + k) % NUM_REQ;
         cand_idx = ID_W'(cand);
         if (!grant_any && req_valid[cand_idx]) begin
            grant_any = 1'b1;
            grant_idx = cand_idx;
         end
      end
   end

   // The grant is combinational so the producer sees acceptance in the same
   // cycle. It is suppressed while reset is asserted, because the FSM ignores
   // the grant in that cycle.
   logic [NUM_REQ-1:0] onehot_one;
   assign onehot_one = {{(NUM_REQ-1){1'b0}}, 1'b1};
   assign req_ready  = (state == IDLE && grant_any && !reset)
                       ? (onehot_one << grant_idx) : '0;

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= IDLE;
         ptr    <= ID_W'(NUM_REQ - 1);
         id_l   <= '0;
         shreg  <= '0;
         data_l <= '0;
         cnt    <= '0;
         acc    <= 1'b0;
         odd_l  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (grant_any) begin
                  shreg  <= req_data[grant_idx*DATA_W +: DATA_W];
                  data_l <= req_data[grant_idx*DATA_W +: DATA_W];
                  id_l   <= grant_idx;
                  odd_l  <= odd_mode;
                  ptr    <= grant_idx;
                  cnt    <= '0;
                  acc    <= 1'b0;
                  state  <= SHIFT;
               end
            end
            SHIFT: begin
               acc   <= acc ^ shreg[0];
               shreg <= shreg >> 1;
               if (cnt == LAST_CNT) begin
                  cnt   <= '0;
                  state <= DONE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            DONE: begin
               if (res_ready) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // All outputs are decoded from registered state. They are forced to zero
   // outside the state that owns them.
   assign ser_valid  = (state == SHIFT);
   assign ser_bit    = ser_valid & shreg[0];
   assign ser_first  = ser_valid && (cnt == '0);
   assign ser_last   = ser_valid && (cnt == LAST_CNT);
   assign res_valid  = (state == DONE);
   assign res_parity = res_valid & (acc ^ odd_l);
   assign res_id     = res_valid ? id_l : '0;
   assign res_data   = res_valid ? data_l : '0;
   assign busy       = (state != IDLE);

endmodule

// File: tb/tb_parity_frame_scheduler.sv
module tb_parity_frame_scheduler;

  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 8;
  localparam int ID_W    = 2;
  localparam int DW      = NUM_REQ * DATA_W;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [NUM_REQ-1:0]   req_valid;
  logic [DW-1:0]        req_data;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 odd_mode;
  logic                 ser_valid, ser_bit, ser_first, ser_last;
  logic                 res_valid, res_ready, res_parity;
  logic [ID_W-1:0]      res_id;
  logic [DATA_W-1:0]    res_data;
  logic                 busy;

  parity_frame_scheduler #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .ID_W(ID_W)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .odd_mode(odd_mode),
    .ser_valid(ser_valid), .ser_bit(ser_bit), .ser_first(ser_first), .ser_last(ser_last),
    .res_valid(res_valid), .res_ready(res_ready), .res_parity(res_parity),
    .res_id(res_id), .res_data(res_data), .busy(busy)
  );

  // clock / reset
  always #5 clk = ~clk;

  // expected per-cycle response
  typedef struct packed {
    logic [NUM_REQ-1:0] rdy;
    logic               sv, sb, sf, sl;
    logic               rv, rp;
    logic [ID_W-1:0]    rid;
    logic [DATA_W-1:0]  rd;
    logic               bsy;
    int                 cyc;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  // reference model: a frame granted at cycle t owns cycles t+1..t+DATA_W for
  // its bits, then presents its result until the first cycle with res_ready
  int                 m_active = 0;
  int                 m_t      = 0;
  int                 m_ptr    = NUM_REQ - 1;
  int                 m_id     = 0;
  logic [DATA_W-1:0]  m_data   = '0;
  logic               m_par    = 1'b0;

  task automatic step(input logic rst_i, input logic [NUM_REQ-1:0] v,
                      input logic [DW-1:0] d, input logic om, input logic rr);
    exp_t e;
    int   dlt;
    int   g;
    @(posedge clk);
    #1;
    reset = rst_i; req_valid = v; req_data = d; odd_mode = om; res_ready = rr;
    cyc++;
    if (rst_i) begin
      m_active = 0;
      m_ptr    = NUM_REQ - 1;
    end else begin
      e     = '0;
      e.cyc = cyc;
      e.bsy = (m_active != 0);
      if (m_active != 0) begin
        dlt = cyc - m_t;
        if (dlt <= DATA_W) begin
          e.sv = 1'b1;
          e.sb = m_data[dlt-1];
          e.sf = (dlt == 1);
          e.sl = (dlt == DATA_W);
        end else begin
          e.rv  = 1'b1;
          e.rp  = m_par;
          e.rid = ID_W'(m_id);
          e.rd  = m_data;
          if (rr) m_active = 0;
        end
      end else if (|v) begin
        g = -1;
        for (int k = 1; k <= NUM_REQ; k++) begin
          if (g < 0 && v[(m_ptr + k) % NUM_REQ]) g = (m_ptr + k) % NUM_REQ;
        end
        e.rdy[g] = 1'b1;
        m_active = 1;
        m_t      = cyc;
        m_id     = g;
        m_ptr    = g;
        m_data   = d[g*DATA_W +: DATA_W];
        m_par    = (^m_data) ^ om;
      end
      exp_q.push_back(e);
    end
  endtask

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] r;
    for (int i = 0; i < DW; i += 32) r[i +: 32] = $urandom();
    return r;
  endfunction

  function automatic logic [DW-1:0] put(input int slot, input logic [DATA_W-1:0] w);
    logic [DW-1:0] r;
    r = rand_data();
    r[slot*DATA_W +: DATA_W] = w;
    return r;
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, rand_data(), $urandom_range(0, 1), 1'b1);
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (req_ready !== e.rdy) begin
        failures++;
        $display("FAIL req_ready cyc=%0d got=%b exp=%b", e.cyc, req_ready, e.rdy);
      end
      checks++;
      if ({ser_valid, ser_bit, ser_first, ser_last} !== {e.sv, e.sb, e.sf, e.sl}) begin
        failures++;
        $display("FAIL ser cyc=%0d got v/b/f/l=%b%b%b%b exp=%b%b%b%b", e.cyc,
                 ser_valid, ser_bit, ser_first, ser_last, e.sv, e.sb, e.sf, e.sl);
      end
      checks++;
      if ({res_valid, res_parity, res_id, res_data} !== {e.rv, e.rp, e.rid, e.rd}) begin
        failures++;
        $display("FAIL res cyc=%0d got v=%b p=%b id=%0d d=%h exp v=%b p=%b id=%0d d=%h",
                 e.cyc, res_valid, res_parity, res_id, res_data, e.rv, e.rp, e.rid, e.rd);
      end
      checks++;
      if (busy !== e.bsy) begin
        failures++;
        $display("FAIL busy cyc=%0d got=%b exp=%b", e.cyc, busy, e.bsy);
      end
    end
  end

  // stimulus
  initial begin
    reset = 1'b1; req_valid = '0; req_data = '0; odd_mode = 1'b0; res_ready = 1'b0;
    for (int i = 0; i < 3; i++) step(1'b1, '0, '0, 1'b0, 1'b0);
    idle(2);

    // single requester, known words and modes
    step(1'b0, 4'b0100, put(2, 8'hA5), 1'b0, 1'b1); idle(12);
    step(1'b0, 4'b0001, put(0, 8'h07), 1'b1, 1'b1); idle(12);
    step(1'b0, 4'b0001, put(0, 8'h07), 1'b0, 1'b1); idle(12);
    step(1'b0, 4'b0010, put(1, 8'hFF), 1'b0, 1'b1); idle(12);
    step(1'b0, 4'b1000, put(3, 8'h80), 1'b0, 1'b1); idle(12);

    // all requesters held from a fresh pointer
    step(1'b1, '0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 52; i++) step(1'b0, 4'b1111, rand_data(), $urandom_range(0, 1), 1'b1);
    idle(12);

    // result held while the consumer stalls, requests pending
    step(1'b0, 4'b0010, rand_data(), 1'b1, 1'b0);
    for (int i = 0; i < 8 + 5; i++) step(1'b0, 4'b1111, rand_data(), 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 4'b1111, rand_data(), 1'b0, 1'b1);
    idle(12);

    // reset in the middle of a frame
    step(1'b0, 4'b0100, rand_data(), 1'b0, 1'b1);
    idle(3);
    step(1'b1, '0, rand_data(), 1'b0, 1'b1);
    idle(2);
    step(1'b0, 4'b1111, rand_data(), 1'b0, 1'b1);
    idle(12);

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      step(($urandom_range(0, 299) == 0), NUM_REQ'($urandom_range(0, 15)) & NUM_REQ'($urandom_range(0, 15)),
           rand_data(), $urandom_range(0, 1), ($urandom_range(0, 3) != 0));
    end
    idle(14);

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain got=%0d exp=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
